// File: rtl/sync_filter_pkg.sv
// -----------------------------------------------------------------------------
// sync_filter_pkg
// Shared helpers for the synchroniser/filter library blocks: the stability
// counter width function and the parameter-legality checks used at
// elaboration time. No ports; import with sync_filter_pkg::*.
// -----------------------------------------------------------------------------
package sync_filter_pkg;

  localparam int STAGES_MIN     = 32'sd2;
  localparam int STAGES_MAX     = 32'sd4;
  localparam int FILTER_CNT_MIN = 32'sd1;

  // Counter must hold 0..FILTER_CNT, i.e. clog2(FILTER_CNT+1) bits (min 1).
  function automatic int cnt_width(input int filter_cnt);
    int w;
    if (filter_cnt < FILTER_CNT_MIN) begin
      w = 32'sd1;
    end else begin
      w = $clog2(filter_cnt + 32'sd1);
    end
    return w;
  endfunction

  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

  function automatic bit filter_cnt_legal(input int filter_cnt);
    return filter_cnt >= FILTER_CNT_MIN;
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// -----------------------------------------------------------------------------
// sync_filter_bit
// One channel of sync_filter: STAGES-deep synchroniser chain, stability
// counter, filtered output register and registered rise/fall pulses.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset_n  - synchronous active-low reset
//   in_bit   - asynchronous level input
//   sync_raw - last synchroniser stage (unfiltered)
//   out      - filtered level
//   rise     - one-cycle pulse on out 0->1
//   fall     - one-cycle pulse on out 1->0
// -----------------------------------------------------------------------------
module sync_filter_bit
  import sync_filter_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 4,
  parameter logic RESET_BIT  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic sync_raw,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = cnt_width(FILTER_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

  logic [STAGES-1:0] chain_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              out_r;
  logic              rise_r;
  logic              fall_r;
  logic              diff_s;
  logic              settle_s;

  // Synchroniser chain: shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain_r <= {STAGES{RESET_BIT}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], in_bit};
    end
  end

  assign sync_raw = chain_r[STAGES-1];

  // Disagreement detect; settle when the disagreement has lasted FILTER_CNT cycles.
  always_comb begin
    diff_s   = 1'b0;
    settle_s = 1'b0;
    diff_s   = sync_raw ^ out_r;
    if (diff_s && (cnt_r == CNT_LAST)) begin
      settle_s = 1'b1;
    end else begin
      settle_s = 1'b0;
    end
  end

  // Stability counter, filtered level and edge pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      out_r  <= RESET_BIT;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (!diff_s) begin
      // Agreement (or a glitch that returned) restarts the count.
      cnt_r  <= {CNT_W{1'b0}};
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else if (settle_s) begin
      // Pulses are taken from the new value so they coincide with out changing.
      cnt_r  <= {CNT_W{1'b0}};
      out_r  <= sync_raw;
      rise_r <= sync_raw;
      fall_r <= ~sync_raw;
    end else begin
      // Count never passes CNT_LAST because settle_s fires there.
      cnt_r  <= cnt_r + CNT_ONE;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end
  end

  assign out  = out_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/sync_filter.sv
// -----------------------------------------------------------------------------
// sync_filter
// WIDTH independent channels, each synchronised through STAGES flops and then
// debounced: out only changes after sync_raw has disagreed with it for
// FILTER_CNT consecutive cycles. rise/fall pulse on the edge out changes.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset_n  - synchronous active-low reset
//   in       - [WIDTH] asynchronous level inputs
//   sync_raw - [WIDTH] last synchroniser stage, before filtering
//   out      - [WIDTH] filtered, synchronised level
//   rise     - [WIDTH] one-cycle pulse per bit on out 0->1
//   fall     - [WIDTH] one-cycle pulse per bit on out 1->0
// -----------------------------------------------------------------------------
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_CNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] sync_raw,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Reject illegal configurations at elaboration.
  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("sync_filter: STAGES=%0d outside 2..4", STAGES);
  end
  if (!filter_cnt_legal(FILTER_CNT)) begin : g_bad_filter_cnt
    $error("sync_filter: FILTER_CNT=%0d must be >= 1", FILTER_CNT);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_filter_bit #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RESET_BIT  (RESET_VAL[i])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bit   (in[i]),
      .sync_raw (sync_raw[i]),
      .out      (out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_sync_filter
// Directed bench: DUT A is WIDTH=4/STAGES=2/FILTER_CNT=3 (in change before
// edge n -> sync_raw at n+1, out at n+4). DUT B is WIDTH=1/STAGES=3/
// FILTER_CNT=1 (out at n+3).
// -----------------------------------------------------------------------------
module tb_sync_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset_n_b;
  logic [3:0] in_a;
  logic [3:0] sync_raw_a, out_a, rise_a, fall_a;
  logic       in_b;
  logic       sync_raw_b, out_b, rise_b, fall_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_filter #(
    .WIDTH(4), .STAGES(2), .FILTER_CNT(3), .RESET_VAL(4'h0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .in(in_a),
    .sync_raw(sync_raw_a), .out(out_a), .rise(rise_a), .fall(fall_a)
  );

  sync_filter #(
    .WIDTH(1), .STAGES(3), .FILTER_CNT(1), .RESET_VAL(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n_b), .in(in_b),
    .sync_raw(sync_raw_b), .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sit 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle pattern for DUT B: value driven before edge k (0 before release).
  function automatic logic vb(input int k);
    logic [31:0] kk;
    kk = k;
    if (k >= 1) begin
      return kk[0];
    end else begin
      return 1'b0;
    end
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    reset_n_b = 1'b0;
    in_a      = 4'hF;
    in_b      = 1'b0;

    // Reset held 3 cycles with in=F: everything stays at reset values.
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("rst_out",  out_a,      4'h0);
      check("rst_raw",  sync_raw_a, 4'h0);
      check("rst_rise", rise_a,     4'h0);
      check("rst_fall", fall_a,     4'h0);
    end

    // Release: out rises on the 5th edge counted from the first high edge.
    reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("rel_raw",  sync_raw_a, (e >= 2) ? 4'hF : 4'h0);
      check("rel_out",  out_a,      (e >= 5) ? 4'hF : 4'h0);
      check("rel_rise", rise_a,     (e == 5) ? 4'hF : 4'h0);
      check("rel_fall", fall_a,     4'h0);
    end

    // All bits fall together.
    in_a = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("fall_out",  out_a,  (e >= 5) ? 4'h0 : 4'hF);
      check("fall_fall", fall_a, (e == 5) ? 4'hF : 4'h0);
      check("fall_rise", rise_a, 4'h0);
    end

    // Two-cycle glitch on bit 0 is filtered out.
    for (int e = 1; e <= 7; e++) begin
      in_a = (e <= 2) ? 4'h1 : 4'h0;
      tick();
      check("glitch_raw",  sync_raw_a, (e == 2 || e == 3) ? 4'h1 : 4'h0);
      check("glitch_out",  out_a,  4'h0);
      check("glitch_rise", rise_a, 4'h0);
      check("glitch_fall", fall_a, 4'h0);
    end

    // Bit 2 up, then bit 1 toggles independently.
    in_a = 4'h4;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("b2_out",  out_a,  (e >= 5) ? 4'h4 : 4'h0);
      check("b2_rise", rise_a, (e == 5) ? 4'h4 : 4'h0);
    end
    in_a = 4'h6;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("b1up_out",  out_a,  (e >= 5) ? 4'h6 : 4'h4);
      check("b1up_rise", rise_a, (e == 5) ? 4'h2 : 4'h0);
      check("b1up_fall", fall_a, 4'h0);
    end
    in_a = 4'h4;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("b1dn_out",  out_a,  (e >= 5) ? 4'h4 : 4'h6);
      check("b1dn_fall", fall_a, (e == 5) ? 4'h2 : 4'h0);
      check("b1dn_rise", rise_a, 4'h0);
    end
    in_a = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("b2dn_out",  out_a,  (e >= 5) ? 4'h0 : 4'h4);
      check("b2dn_fall", fall_a, (e == 5) ? 4'h4 : 4'h0);
    end

    // in=F, reset pulse on the 2nd edge: latency restarts from release.
    in_a = 4'hF;
    tick();
    check("rp_e1_out", out_a, 4'h0);
    reset_n = 1'b0;
    tick();
    check("rp_rst_out", out_a,      4'h0);
    check("rp_rst_raw", sync_raw_a, 4'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("rp_out",  out_a,  (e >= 5) ? 4'hF : 4'h0);
      check("rp_rise", rise_a, (e == 5) ? 4'hF : 4'h0);
      check("rp_fall", fall_a, 4'h0);
    end

    // Reset in the middle of a falling count: no fall pulse ever appears.
    in_a = 4'h0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("mid_out", out_a, 4'hF);
    end
    reset_n = 1'b0;
    tick();
    check("mid_rst_out",  out_a,  4'h0);
    check("mid_rst_fall", fall_a, 4'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("mid_out0", out_a,  4'h0);
      check("mid_fall", fall_a, 4'h0);
      check("mid_rise", rise_a, 4'h0);
    end

    // DUT B: STAGES=3, FILTER_CNT=1, input toggling every cycle.
    tick();
    check("b_rst_out", {3'b000, out_b}, 4'h0);
    reset_n_b = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      in_b = vb(j);
      tick();
      check("b_raw",  {3'b000, sync_raw_b}, {3'b000, vb(j - 2)});
      check("b_out",  {3'b000, out_b},      {3'b000, vb(j - 3)});
      check("b_rise", {3'b000, rise_b},     {3'b000, vb(j - 3) & ~vb(j - 4)});
      check("b_fall", {3'b000, fall_b},     {3'b000, ~vb(j - 3) & vb(j - 4)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent bit channels.
REQ-002 Parameter: STAGES, default 2, synchroniser flop depth; legal range 2 to 4.
REQ-003 Parameter: FILTER_CNT, default 4, consecutive stable cycles required before the output changes; legal minimum 1 (1 = no filtering).
REQ-004 Parameter: RESET_VAL, default 0, WIDTH-bit value loaded into all level state at reset.
REQ-005 Port: clk  input  1  sole clock; all state is updated on its rising edge.
REQ-006 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-007 Port: in  input  WIDTH  asynchronous level inputs.
REQ-008 Port: sync_raw  output  WIDTH  last synchroniser stage, before filtering.
REQ-009 Port: out  output  WIDTH  filtered, synchronised level.
REQ-010 Port: rise  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of out.
REQ-011 Port: fall  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of out.

Function
REQ-012 The block SHALL use a STAGES-deep flop chain per bit; a change on in before edge n SHALL appear on sync_raw at edge n+STAGES-1.
REQ-013 Each bit SHALL have a saturating stability counter of width clog2(FILTER_CNT+1), with no cross-bit interaction.
REQ-014 When sync_raw equals out for a bit, that bit's counter SHALL be cleared to 0.
REQ-015 When sync_raw differs from out and the counter is below FILTER_CNT-1, the counter SHALL increment.
REQ-016 When sync_raw differs from out and the counter equals FILTER_CNT-1, the block SHALL load out from sync_raw and clear the counter on the same edge.
REQ-017 End-to-end latency from an in change (set up before edge n) to out SHALL be STAGES+FILTER_CNT-1 edges after n, giving out update at edge n+STAGES+FILTER_CNT-1.
REQ-018 A sync_raw excursion shorter than FILTER_CNT cycles SHALL leave out, rise and fall unchanged, and the counter SHALL restart from 0 on the return.
REQ-019 rise and fall SHALL be registered and assert on the same edge that out changes, for exactly one cycle.
REQ-020 rise and fall SHALL never both be high on the same bit.
REQ-021 With FILTER_CNT=1, out SHALL follow sync_raw with one cycle delay, and alternating rise/fall pulses SHALL occur on consecutive cycles.
REQ-022 Illegal parameter values (STAGES outside 2..4, FILTER_CNT<1) SHALL cause an elaboration error.

Reset
REQ-023 While reset_n is low at a clk edge, all synchroniser flops, out and sync_raw SHALL load RESET_VAL, all counters SHALL load 0, and rise and fall SHALL load 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count, with no pulse generated.
REQ-025 After reset release, no rise/fall SHALL occur before the full REQ-017 latency has elapsed, even if in differs from RESET_VAL.

Structure
REQ-026 A shared package SHALL hold the clog2 counter-width function and the parameter-legality checks for reuse by other library blocks.
REQ-027 Per-bit logic (chain, counter, out/rise/fall registers) SHALL be one sub-module, sync_filter_bit, instantiated WIDTH times by generate.

Verification (WIDTH=4, STAGES=2, FILTER_CNT=3, RESET_VAL=0 unless stated)
REQ-028 The bench SHALL cover: reset_n low for 3 cycles with in=4'hF, then released -> out=0 during reset; out=4'hF and rise=4'hF for one cycle at the 4th edge after release; fall=0 throughout.
REQ-029 The bench SHALL cover: out=4'h0, in[0] high for exactly 2 cycles -> sync_raw[0] pulses for 2 cycles; out, rise and fall stay 0.
REQ-030 The bench SHALL cover: out=4'hF, in=4'h0 held -> out=4'h0 at edge +4 and fall=4'hF for one cycle; rise stays 0.
REQ-031 The bench SHALL cover: in[1] toggled high while in[2] is held high -> only out[1]/rise[1] change; bit 2 is unaffected.
REQ-032 The bench SHALL cover: in=4'hF, reset_n low at the 2nd edge for 1 cycle, in still F -> out stays 0 until 4 edges after release; no early rise.
REQ-033 The bench SHALL cover: STAGES=3, FILTER_CNT=1, in[0] toggled every cycle -> out[0] follows with 3-edge latency; rise[0] and fall[0] alternate every cycle.
